// File: rtl/prog_loader.sv
// Instruction-store loader: takes a length-prefixed, XOR-checksummed byte frame and
// writes 9-bit words into instruction memory, holding the core in reset until verified.
module prog_loader #(
  parameter int D = 10,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         hold,
  output logic         busy,
  output logic         load_done,
  output logic         err,
  output logic [2:0]   state_dbg
);

  // Handshake: a byte transfers on a rising clk edge when in_valid && in_ready.
  // in_ready is decoded from the state register only; the host may hold
  // in_valid high across bytes and one byte is taken per accepting cycle.

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_W_LO, S_W_HI, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << D;
  localparam logic [D:0]  CNT_ONE = 1;

  state_t       state_q, state_d;
  logic [15:0]  len_q;
  logic [D:0]   count_q;
  logic [7:0]   lo_q;
  logic [7:0]   csum_q;

  logic         accept;
  logic         start_ok;
  logic [15:0]  len_full;
  logic         len_bad;
  logic         hi_bad;
  logic         last_word;
  logic         csum_ok;

  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign len_full  = {in_data, len_q[7:0]};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH);
  assign hi_bad    = |in_data[7:1];
  assign last_word = (17'(count_q) + 17'd1) == {1'b0, len_q};
  assign csum_ok   = (csum_q ^ in_data) == 8'd0;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)  state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = len_bad ? S_ERR : S_W_LO;
      S_W_LO:   if (accept) state_d = S_W_HI;
      S_W_HI:   if (accept) state_d = hi_bad ? S_ERR : (last_word ? S_CSUM : S_W_LO);
      S_CSUM:   if (accept) state_d = csum_ok ? S_DONE : S_ERR;
      S_DONE:   if (start)  state_d = S_LEN_LO;
      S_ERR:    if (start)  state_d = S_LEN_LO;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    hold      = 1'b1;
    load_done = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_W_LO, S_W_HI, S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        hold      = 1'b0;
        load_done = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // The running checksum folds in every accepted byte; the checksum byte itself
  // is only compared, so the value left behind after CSUM is irrelevant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      count_q <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_ok) begin
        len_q   <= '0;
        count_q <= '0;
        csum_q  <= '0;
        wr_addr <= '0;
      end
      if (accept) begin
        csum_q <= csum_q ^ in_data;
        case (state_q)
          S_LEN_LO: len_q[7:0]  <= in_data;
          S_LEN_HI: len_q[15:8] <= in_data;
          S_W_LO:   lo_q        <= in_data;
          S_W_HI: begin
            if (!hi_bad) begin
              wr_en   <= 1'b1;
              wr_addr <= count_q[D-1:0];
              wr_data <= W'({in_data[0], lo_q});
              count_q <= count_q + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are built and decoded by a byte-level model,
// and a per-cycle compare process checks writes, address/data stability and status flags.
module tb_prog_loader;
  localparam int D = 10;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         hold;
  logic         busy;
  logic         load_done;
  logic         err;
  logic [2:0]   state_dbg;

  prog_loader #(.D(D), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hold(hold), .busy(busy), .load_done(load_done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [D+W-1:0] exp_q[$];
  logic [7:0]     frame_q[$];
  logic [8:0]     words_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame layout: N lo, N hi, N x {word[7:0], {7'b0, word[8]}}, XOR of all preceding bytes.
  task automatic make_frame(input int n);
    logic [7:0] x;
    frame_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    foreach (words_q[i]) begin
      frame_q.push_back(words_q[i][7:0]);
      frame_q.push_back({7'b0, words_q[i][8]});
    end
    x = 8'd0;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    frame_q.push_back(x);
  endtask

  // Decodes frame_q the way the loader must, queues the writes that must appear,
  // and returns 1 when the session must end in error.
  function automatic bit predict();
    int n;
    logic [7:0] x, lo, hi;
    n = int'({frame_q[1], frame_q[0]});
    if (n == 0 || n > (1 << D)) return 1'b1;
    x = frame_q[0] ^ frame_q[1];
    for (int i = 0; i < n; i++) begin
      lo = frame_q[2 + 2 * i];
      hi = frame_q[3 + 2 * i];
      x = x ^ lo ^ hi;
      if (hi > 8'd1) return 1'b1;
      exp_q.push_back({D'(i), hi[0], lo});
    end
    return x != frame_q[2 + 2 * n];
  endfunction

  // ---------------- compare process ----------------
  logic [D-1:0]   m_addr;
  logic [W-1:0]   m_data;
  logic           prev_busy;
  logic [D+W-1:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      m_addr    = '0;
      m_data    = '0;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) m_addr = '0;
      if (wr_en) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[D+W-1:W]);
          check("wr_data", wr_data, e[W-1:0]);
          m_addr = e[D+W-1:W];
          m_data = e[W-1:0];
        end
      end else begin
        check("addr_stable", wr_addr, m_addr);
        check("data_stable", wr_data, m_data);
      end
      check("ready_eq_busy", in_ready, busy);
      check("hold_vs_done", hold, !load_done);
      check("done_err_excl", load_done && err, 0);
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clr", err, 0);
    check("start_hold", hold, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit accepted;
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (n) begin
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    accepted = 1'b0;
    for (int t = 0; t < 50 && !accepted; t++) begin
      if (in_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    if (!accepted) check("accept_timeout", accepted, 1);
  endtask

  task automatic send_bytes(input int nb, input bit gaps);
    for (int k = 0; k < nb; k++) begin
      if (!busy) break;
      send_byte(frame_q[k], gaps);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_session(input string name, input bit do_start, input bit gaps);
    bit exp_err;
    exp_err = predict();
    if (do_start) pulse_start();
    send_bytes(frame_q.size(), gaps);
    repeat (3) begin @(posedge clk); #1; end
    check({name, "_writes_left"}, exp_q.size(), 0);
    check({name, "_load_done"}, load_done, !exp_err);
    check({name, "_err"}, err, exp_err);
    check({name, "_hold"}, hold, exp_err);
    check({name, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", hold, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Basic three-word image, host keeps in_valid high.
    words_q = '{9'h001, 9'h1FF, 9'h010};
    make_frame(3);
    check("model_csum_byte", frame_q[8], 8'hEC);
    run_session("basic", 1, 0);
    check("basic_last_addr", wr_addr, 2);
    check("basic_last_data", wr_data, 9'h010);

    // Same image with the checksum byte flipped: all writes land, then error.
    make_frame(3);
    frame_q[8] = frame_q[8] ^ 8'h01;
    check("model_bad_csum_byte", frame_q[8], 8'hED);
    run_session("bad_csum", 1, 0);

    // Zero length, then restart and present an over-long length in the same session.
    frame_q = '{8'h00, 8'h00};
    run_session("len_zero", 1, 0);
    pulse_start();
    frame_q = '{8'h01, 8'h04};
    run_session("len_1025", 0, 0);

    // Largest image: every address written once.
    words_q.delete();
    for (int i = 0; i < (1 << D); i++) words_q.push_back(9'($urandom_range(0, 511)));
    make_frame(1 << D);
    run_session("full", 1, 0);
    check("full_last_addr", wr_addr, 10'd1023);

    // Illegal high byte on the second word.
    words_q = '{9'h055, 9'h0AA};
    make_frame(2);
    frame_q[5] = 8'h03;
    run_session("bad_hi", 1, 0);
    check("bad_hi_addr", wr_addr, 0);
    check("bad_hi_data", wr_data, 9'h055);

    // Irregular in_valid with stray start pulses while busy.
    words_q.delete();
    for (int i = 0; i < 6; i++) words_q.push_back(9'($urandom_range(0, 511)));
    make_frame(6);
    run_session("gappy", 1, 1);
    check("gappy_last_addr", wr_addr, 5);

    // Asynchronous reset while waiting for the third word's high byte.
    words_q = '{9'h123, 9'h0FE, 9'h1A5, 9'h077};
    make_frame(4);
    void'(predict());
    pulse_start();
    send_bytes(7, 0);
    check("midrst_writes_seen", exp_q.size(), 2);
    #2 reset = 1'b0;
    #1;
    check("midrst_hold", hold, 1);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    words_q = '{9'h100, 9'h0C3, 9'h03C};
    make_frame(3);
    run_session("after_rst", 1, 0);
    check("after_rst_last_addr", wr_addr, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
